// File: rtl/y_mux4to1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// y_mux4to1 : SIZE-bit 4-to-1 mux built as a gate-level 2-to-1 tree, with a
//             registered copy z_q.                           rev 1.0
// ---------------------------------------------------------------------------
module y_mux4to1 #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c,
  output logic [SIZE-1:0] z_q
);

  logic [SIZE-1:0] lo;
  logic [SIZE-1:0] hi;
  logic            s0_n;
  logic            s1_n;

  assign s0_n = ~c[0];
  assign s1_n = ~c[1];

  // Each lane is an independent (a & ~s) | (b & s) tree; c[0] picks within a pair.
  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign lo[i] = (a0[i] & s0_n) | (a1[i] & c[0]);
    assign hi[i] = (a2[i] & s0_n) | (a3[i] & c[0]);
    assign z[i]  = (lo[i] & s1_n) | (hi[i] & c[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y_mux4to1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_y_mux4to1 : self-checking bench for y_mux4to1 (SIZE=32 and SIZE=1).
// ---------------------------------------------------------------------------
module tb_y_mux4to1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a0, a1, a2, a3;
  logic [1:0]  c;
  logic [31:0] z, z_q;

  logic        b0, b1, b2, b3;
  logic [1:0]  bc;
  logic        bz, bz_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  y_mux4to1 #(.SIZE(32)) dut (
    .clk(clk), .rst(rst), .z(z), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .c(c), .z_q(z_q)
  );

  y_mux4to1 #(.SIZE(1)) dut1 (
    .clk(clk), .rst(rst), .z(bz), .a0(b0), .a1(b1), .a2(b2), .a3(b3),
    .c(bc), .z_q(bz_q)
  );

  // Reference: pick the input whose index equals the select value.
  function automatic logic [31:0] ref_mux(input logic [31:0] x0, x1, x2, x3,
                                          input logic [1:0] s);
    logic [31:0] bank [4];
    bank[0] = x0; bank[1] = x1; bank[2] = x2; bank[3] = x3;
    return bank[s];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    a0 = 32'hDEADBEEF; a1 = 32'h0; a2 = 32'h0; a3 = 32'h0; c = 2'd0;
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if (z_q !== 32'h0) begin
        failures++;
        $display("FAIL reset_zq edge%0d: got %h want %h", e, z_q, 32'h0);
      end
      checks++;
      if (z !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL reset_z edge%0d: got %h want %h", e, z, 32'hDEADBEEF);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (z_q !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", z_q, 32'hDEADBEEF);
    end
  endtask

  task automatic test_sweep();
    a0 = 32'h11111111; a1 = 32'h22222222; a2 = 32'h33333333; a3 = 32'h44444444;
    for (int s = 0; s < 4; s++) begin
      c = 2'(s);
      #1;
      checks++;
      if (z !== 32'h11111111 * (s + 1)) begin
        failures++;
        $display("FAIL sweep c=%0d: got %h want %h", s, z, 32'h11111111 * (s + 1));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int n = 0; n < 10; n++) begin
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      c  = 2'($urandom_range(0, 3));
      #1;
      exp = ref_mux(a0, a1, a2, a3, c);
      checks++;
      if (z !== exp) begin
        failures++;
        $display("FAIL random%0d c=%0d: got %h want %h", n, c, z, exp);
      end
    end
  endtask

  task automatic test_toggle();
    a0 = 32'h0; a1 = 32'hFFFFFFFF; a2 = $urandom; a3 = $urandom;
    for (int n = 0; n < 6; n++) begin
      c = 2'(n % 2);
      #1;
      checks++;
      if (z !== ((n % 2) ? 32'hFFFFFFFF : 32'h0)) begin
        failures++;
        $display("FAIL toggle%0d: got %h want %h", n, z,
                 (n % 2) ? 32'hFFFFFFFF : 32'h0);
      end
    end
  endtask

  task automatic test_midchange();
    @(negedge clk);
    a0 = 32'h0; a1 = 32'h0; a2 = 32'd5; a3 = 32'd9; c = 2'd2;
    @(posedge clk); #1;
    checks++;
    if (z_q !== 32'd5) begin
      failures++;
      $display("FAIL mid_capture: got %h want %h", z_q, 32'd5);
    end
    @(negedge clk);
    c = 2'd3;
    #1;
    checks++;
    if (z !== 32'd9) begin
      failures++;
      $display("FAIL mid_z: got %h want %h", z, 32'd9);
    end
    checks++;
    if (z_q !== 32'd5) begin
      failures++;
      $display("FAIL mid_hold: got %h want %h", z_q, 32'd5);
    end
    @(posedge clk); #1;
    checks++;
    if (z_q !== 32'd9) begin
      failures++;
      $display("FAIL mid_update: got %h want %h", z_q, 32'd9);
    end
  endtask

  // Random stream through the register, with a reset pulse in the middle.
  task automatic test_back_to_back();
    logic [31:0] exp_q;
    exp_q = z_q;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      c  = 2'($urandom_range(0, 3));
      rst = (n == 10);
      #1;
      checks++;
      if (z_q !== exp_q) begin
        failures++;
        $display("FAIL b2b_hold%0d: got %h want %h", n, z_q, exp_q);
      end
      exp_q = rst ? 32'h0 : ref_mux(a0, a1, a2, a3, c);
      @(posedge clk); #1;
      checks++;
      if (z_q !== exp_q) begin
        failures++;
        $display("FAIL b2b_edge%0d: got %h want %h", n, z_q, exp_q);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_size1();
    logic [5:0] v;
    logic       exp;
    for (int n = 0; n < 64; n++) begin
      v = 6'(n);
      {bc, b3, b2, b1, b0} = v;
      #1;
      exp = v[bc];
      checks++;
      if (bz !== exp) begin
        failures++;
        $display("FAIL size1 v=%0d: got %b want %b", n, bz, exp);
      end
    end
  endtask

  initial begin
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; c = 2'd0;
    b0 = 1'b0; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; bc = 2'd0;
    test_reset();
    test_sweep();
    test_random();
    test_toggle();
    test_midchange();
    test_back_to_back();
    test_size1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
